// File: rtl/ddr_wr_scheduler.sv
// Splits finished video lines into DDR write bursts of up to g_MAX_BURST beats,
// walking a contiguous line pointer through ping-pong frame buffers.
module ddr_wr_scheduler #(
    parameter int unsigned g_BEAT_BYTES     = 64,
    parameter int unsigned g_WORDS_PER_BEAT = 16,
    parameter int unsigned g_MAX_BURST      = 16
) (
    input  logic        sys_clk_i,
    input  logic        rst_i,
    input  logic        frame_valid_i,
    input  logic        line_done_i,
    input  logic [15:0] h_count_i,
    input  logic [31:0] base0_i,
    input  logic [31:0] base1_i,
    output logic        wr_req_o,
    output logic [31:0] wr_addr_o,
    output logic [7:0]  wr_len_o,
    input  logic        wr_ack_i,
    input  logic        wr_done_i,
    output logic        busy_o,
    output logic        buf_sel_o,
    output logic [15:0] line_cnt_o,
    output logic        overflow_o,
    output logic        frame_done_o
);

    localparam int unsigned REM_W   = 17;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned BURST_W = 9;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_DONE} state_t;

    state_t             state_q, state_d;
    logic [REM_W-1:0]   beats_rem_q, beats_rem_d;
    logic [31:0]        ptr_q, ptr_d;
    logic [7:0]         wr_len_q, wr_len_d;
    logic               buf_sel_q, buf_sel_d;
    logic [CNT_W-1:0]   line_cnt_q, line_cnt_d;
    logic               overflow_q, overflow_d;
    logic               frame_done_q, frame_done_d;
    logic               start_pend_q, start_pend_d;
    logic               done_pend_q, done_pend_d;
    logic               fv_q;
    logic               wr_req_q;
    logic               busy_q;

    logic               fv_rise;
    logic [REM_W-1:0]   line_beats;
    logic [BURST_W-1:0] burst;

    function automatic logic [BURST_W-1:0] min_burst(input logic [REM_W-1:0] rem);
        if (rem > REM_W'(g_MAX_BURST)) begin
            return BURST_W'(g_MAX_BURST);
        end
        return BURST_W'(rem);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    assign fv_rise    = frame_valid_i & ~fv_q;
    assign line_beats = (REM_W'(h_count_i) + REM_W'(g_WORDS_PER_BEAT - 1)) / REM_W'(g_WORDS_PER_BEAT);
    assign burst      = min_burst(beats_rem_q);

    // Next-state: line/burst sequencing, frame start handling and bookkeeping
    always_comb begin
        state_d      = state_q;
        beats_rem_d  = beats_rem_q;
        ptr_d        = ptr_q;
        wr_len_d     = wr_len_q;
        buf_sel_d    = buf_sel_q;
        line_cnt_d   = line_cnt_q;
        overflow_d   = overflow_q;
        frame_done_d = 1'b0;
        start_pend_d = start_pend_q;
        done_pend_d  = done_pend_q;

        case (state_q)
            S_IDLE: begin
                if (done_pend_q && !frame_valid_i) begin
                    frame_done_d = 1'b1;
                    done_pend_d  = 1'b0;
                end
                // A new frame applies before a coincident line_done is accepted
                if (fv_rise) begin
                    buf_sel_d    = ~buf_sel_q;
                    ptr_d        = buf_sel_q ? base0_i : base1_i;
                    line_cnt_d   = '0;
                    done_pend_d  = 1'b0;
                    start_pend_d = 1'b0;
                end
                if (line_done_i) begin
                    if (line_beats == '0) begin
                        line_cnt_d  = sat_inc(line_cnt_d);
                        done_pend_d = 1'b1;
                    end else begin
                        beats_rem_d = line_beats;
                        state_d     = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (line_done_i) overflow_d = 1'b1;
                if (fv_rise)     start_pend_d = 1'b1;
                if (wr_ack_i) begin
                    ptr_d       = ptr_q + 32'(burst) * 32'(g_BEAT_BYTES);
                    beats_rem_d = beats_rem_q - REM_W'(burst);
                    state_d     = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (line_done_i) overflow_d = 1'b1;
                if (fv_rise)     start_pend_d = 1'b1;
                if (wr_done_i) begin
                    if (beats_rem_q != '0) begin
                        state_d = S_REQ;
                    end else begin
                        line_cnt_d  = sat_inc(line_cnt_q);
                        done_pend_d = 1'b1;
                        state_d     = S_IDLE;
                        // Deferred frame start lands after this line is counted
                        if (start_pend_q || fv_rise) begin
                            buf_sel_d    = ~buf_sel_q;
                            ptr_d        = buf_sel_q ? base0_i : base1_i;
                            line_cnt_d   = '0;
                            done_pend_d  = 1'b0;
                            start_pend_d = 1'b0;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_REQ) begin
            wr_len_d = 8'(min_burst(beats_rem_d) - BURST_W'(1));
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            beats_rem_q  <= '0;
            ptr_q        <= base0_i;
            wr_len_q     <= '0;
            buf_sel_q    <= 1'b0;
            line_cnt_q   <= '0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
            start_pend_q <= 1'b0;
            done_pend_q  <= 1'b0;
            fv_q         <= 1'b0;
            wr_req_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            beats_rem_q  <= beats_rem_d;
            ptr_q        <= ptr_d;
            wr_len_q     <= wr_len_d;
            buf_sel_q    <= buf_sel_d;
            line_cnt_q   <= line_cnt_d;
            overflow_q   <= overflow_d;
            frame_done_q <= frame_done_d;
            start_pend_q <= start_pend_d;
            done_pend_q  <= done_pend_d;
            fv_q         <= frame_valid_i;
            wr_req_q     <= (state_d == S_REQ);
            busy_q       <= (state_d != S_IDLE);
        end
    end

    assign wr_req_o     = wr_req_q;
    assign wr_addr_o    = ptr_q;
    assign wr_len_o     = wr_len_q;
    assign busy_o       = busy_q;
    assign buf_sel_o    = buf_sel_q;
    assign line_cnt_o   = line_cnt_q;
    assign overflow_o   = overflow_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_ddr_wr_scheduler.sv
// Bench for ddr_wr_scheduler: directed scenarios with literal expectations,
// then random traffic, all compared every cycle against a behavioural model.
module tb_ddr_wr_scheduler;

    localparam logic [31:0] B0 = 32'h1000_0000;
    localparam logic [31:0] B1 = 32'h2000_0000;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        frame_valid_i = 1'b0;
    logic        line_done_i = 1'b0;
    logic [15:0] h_count_i = '0;
    logic [31:0] base0_i = B0;
    logic [31:0] base1_i = B1;
    logic        wr_ack_i = 1'b0;
    logic        wr_done_i = 1'b0;
    logic        wr_req_o;
    logic [31:0] wr_addr_o;
    logic [7:0]  wr_len_o;
    logic        busy_o;
    logic        buf_sel_o;
    logic [15:0] line_cnt_o;
    logic        overflow_o;
    logic        frame_done_o;

    always #5 clk = ~clk;

    ddr_wr_scheduler dut (
        .sys_clk_i    (clk),
        .rst_i        (rst_i),
        .frame_valid_i(frame_valid_i),
        .line_done_i  (line_done_i),
        .h_count_i    (h_count_i),
        .base0_i      (base0_i),
        .base1_i      (base1_i),
        .wr_req_o     (wr_req_o),
        .wr_addr_o    (wr_addr_o),
        .wr_len_o     (wr_len_o),
        .wr_ack_i     (wr_ack_i),
        .wr_done_i    (wr_done_i),
        .busy_o       (busy_o),
        .buf_sel_o    (buf_sel_o),
        .line_cnt_o   (line_cnt_o),
        .overflow_o   (overflow_o),
        .frame_done_o (frame_done_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 requesting, 2 awaiting completion
    bit          m_valid = 1'b0;
    int          m_phase, m_left, m_cnt;
    logic [31:0] m_ptr;
    bit          m_sel, m_ovf, m_fd, m_fdpend, m_spend, m_prevfv;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic void new_frame();
        m_sel    = !m_sel;
        m_ptr    = m_sel ? base1_i : base0_i;
        m_cnt    = 0;
        m_fdpend = 1'b0;
        m_spend  = 1'b0;
    endfunction

    function automatic void count_line();
        if (m_cnt < 65535) m_cnt++;
        m_fdpend = 1'b1;
    endfunction

    always @(posedge clk) begin : model
        int b;
        bit rise;
        if (rst_i) begin
            m_valid = 1'b1; m_phase = 0; m_left = 0; m_ptr = base0_i; m_sel = 1'b0;
            m_cnt = 0; m_ovf = 1'b0; m_fd = 1'b0; m_fdpend = 1'b0; m_spend = 1'b0;
            m_prevfv = 1'b0;
        end else if (m_valid) begin
            rise     = frame_valid_i && !m_prevfv;
            m_prevfv = frame_valid_i;
            m_fd     = 1'b0;
            if (m_phase == 0) begin
                if (m_fdpend && !frame_valid_i) begin
                    m_fd = 1'b1; m_fdpend = 1'b0;
                end
                if (rise) new_frame();
                if (line_done_i) begin
                    b = (int'(h_count_i) + 15) / 16;
                    if (b == 0) count_line();
                    else begin m_left = b; m_phase = 1; end
                end
            end else begin
                if (line_done_i) m_ovf = 1'b1;
                if (rise) m_spend = 1'b1;
                if (m_phase == 1) begin
                    if (wr_ack_i) begin
                        b = imin(m_left, 16);
                        m_ptr = m_ptr + 32'(b * 64);
                        m_left -= b;
                        m_phase = 2;
                    end
                end else if (wr_done_i) begin
                    if (m_left > 0) m_phase = 1;
                    else begin
                        count_line();
                        m_phase = 0;
                        if (m_spend) new_frame();
                    end
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        if (m_valid) begin
            chk("wr_req", 32'(wr_req_o), 32'(m_phase == 1));
            if (m_phase == 1) begin
                chk("wr_addr", wr_addr_o, m_ptr);
                chk("wr_len", 32'(wr_len_o), 32'(imin(m_left, 16) - 1));
            end
            chk("busy", 32'(busy_o), 32'(m_phase != 0));
            chk("buf_sel", 32'(buf_sel_o), 32'(m_sel));
            chk("line_cnt", 32'(line_cnt_o), 32'(m_cnt));
            chk("overflow", 32'(overflow_o), 32'(m_ovf));
            chk("frame_done", 32'(frame_done_o), 32'(m_fd));
        end
    end

    // Memory-side responder with random latencies and stray ack/done pulses
    typedef struct { logic [31:0] addr; logic [7:0] len; } burst_t;
    burst_t seen[$];
    bit outstanding = 1'b0;
    int dcnt = 0;

    always @(negedge clk) begin : responder
        wr_ack_i  = 1'b0;
        wr_done_i = 1'b0;
        if (rst_i) begin
            outstanding = 1'b0;
        end else if (outstanding) begin
            if ($urandom_range(0, 7) == 0) wr_ack_i = 1'b1;
            if (dcnt == 0) begin
                wr_done_i   = 1'b1;
                outstanding = 1'b0;
            end else begin
                dcnt--;
            end
        end else if (wr_req_o) begin
            if ($urandom_range(0, 1) == 1) begin
                wr_ack_i    = 1'b1;
                outstanding = 1'b1;
                dcnt        = int'($urandom_range(0, 4));
                seen.push_back('{addr: wr_addr_o, len: wr_len_o});
            end
        end else begin
            if ($urandom_range(0, 11) == 0) wr_ack_i = 1'b1;
            if ($urandom_range(0, 11) == 0) wr_done_i = 1'b1;
        end
    end

    task automatic pulse_line(input logic [15:0] h);
        @(negedge clk);
        line_done_i = 1'b1;
        h_count_i   = h;
        @(negedge clk);
        line_done_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy_o && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(busy_o), 32'd0);
    endtask

    task automatic count_fd(input int cycles, output int cnt);
        cnt = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (frame_done_o) cnt++;
        end
    endtask

    initial begin
        int k;
        int n;
        repeat (3) @(negedge clk);
        chk("rst_req", 32'(wr_req_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_sel", 32'(buf_sel_o), 32'd0);
        chk("rst_cnt", 32'(line_cnt_o), 32'd0);
        chk("rst_addr", wr_addr_o, B0);
        chk("rst_len", 32'(wr_len_o), 32'd0);
        chk("rst_ovf", 32'(overflow_o), 32'd0);
        chk("rst_fd", 32'(frame_done_o), 32'd0);
        rst_i = 1'b0;

        // Frame start then a 1920-word line
        @(negedge clk);
        frame_valid_i = 1'b1;
        @(negedge clk);
        chk("start_sel", 32'(buf_sel_o), 32'd1);
        chk("start_addr", wr_addr_o, B1);
        seen.delete();
        pulse_line(16'd1920);
        wait_idle("idle_1920");
        chk("n_bursts_1920", 32'(seen.size()), 32'd8);
        if (seen.size() == 8) begin
            for (int i = 0; i < 7; i++) begin
                chk("addr_1920", seen[i].addr, B1 + 32'(i * 1024));
                chk("len_1920", 32'(seen[i].len), 32'd15);
            end
            chk("addr_1920_last", seen[7].addr, B1 + 32'd7168);
            chk("len_1920_last", 32'(seen[7].len), 32'd7);
        end
        chk("cnt_1920", 32'(line_cnt_o), 32'd1);

        // 17 words: two beats, next line 128 bytes on
        seen.delete();
        pulse_line(16'd17);
        wait_idle("idle_17");
        pulse_line(16'd1);
        wait_idle("idle_1");
        chk("n_bursts_17", 32'(seen.size()), 32'd2);
        if (seen.size() == 2) begin
            chk("addr_17", seen[0].addr, B1 + 32'd7680);
            chk("len_17", 32'(seen[0].len), 32'd1);
            chk("addr_after_17", seen[1].addr, B1 + 32'd7808);
            chk("len_1", 32'(seen[1].len), 32'd0);
        end
        chk("cnt_17", 32'(line_cnt_o), 32'd3);

        // Empty line
        pulse_line(16'd0);
        chk("zero_busy", 32'(busy_o), 32'd0);
        chk("zero_cnt", 32'(line_cnt_o), 32'd4);
        n = 0;
        repeat (5) begin
            @(negedge clk);
            if (wr_req_o) n++;
        end
        chk("zero_noreq", 32'(n), 32'd0);

        // line_done while waiting for completion
        seen.delete();
        pulse_line(16'd600);
        k = 0;
        while (!(busy_o && !wr_req_o) && k < 200) begin
            @(negedge clk);
            k++;
        end
        pulse_line(16'd50);
        wait_idle("idle_ovf");
        chk("ovf_set", 32'(overflow_o), 32'd1);
        chk("ovf_cnt", 32'(line_cnt_o), 32'd5);
        chk("ovf_bursts", 32'(seen.size()), 32'd3);
        if (seen.size() == 3) begin
            chk("ovf_addr0", seen[0].addr, B1 + 32'd7872);
            chk("ovf_len0", 32'(seen[0].len), 32'd15);
            chk("ovf_len2", 32'(seen[2].len), 32'd5);
        end
        repeat (5) @(negedge clk);
        chk("ovf_sticky", 32'(overflow_o), 32'd1);

        // Frame end, then a frame start deferred by a busy line
        frame_valid_i = 1'b0;
        count_fd(10, n);
        chk("fd_once_a", 32'(n), 32'd1);
        seen.delete();
        pulse_line(16'd600);
        frame_valid_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("defer_sel_hold", 32'(buf_sel_o), 32'd1);
        chk("defer_busy", 32'(busy_o), 32'd1);
        wait_idle("idle_defer");
        chk("defer_sel", 32'(buf_sel_o), 32'd0);
        chk("defer_cnt", 32'(line_cnt_o), 32'd0);
        if (seen.size() > 0) chk("defer_line_addr", seen[0].addr, B1 + 32'd10304);
        seen.delete();
        pulse_line(16'd16);
        wait_idle("idle_newbuf");
        chk("newbuf_bursts", 32'(seen.size()), 32'd1);
        if (seen.size() == 1) chk("newbuf_addr", seen[0].addr, B0);
        chk("newbuf_cnt", 32'(line_cnt_o), 32'd1);
        frame_valid_i = 1'b0;
        count_fd(10, n);
        chk("fd_once_b", 32'(n), 32'd1);

        // Reset while a request is pending
        pulse_line(16'd1920);
        k = 0;
        while (!wr_req_o && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("pre_rst_req", 32'(wr_req_o), 32'd1);
        rst_i = 1'b1;
        @(negedge clk);
        chk("mid_rst_req", 32'(wr_req_o), 32'd0);
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        chk("mid_rst_sel", 32'(buf_sel_o), 32'd0);
        chk("mid_rst_cnt", 32'(line_cnt_o), 32'd0);
        rst_i = 1'b0;
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (wr_req_o) n++;
        end
        chk("post_rst_noreq", 32'(n), 32'd0);

        // line_done coincident with a frame start uses the new buffer
        seen.delete();
        @(negedge clk);
        frame_valid_i = 1'b1;
        line_done_i   = 1'b1;
        h_count_i     = 16'd16;
        @(negedge clk);
        line_done_i   = 1'b0;
        wait_idle("idle_coincide");
        chk("coincide_bursts", 32'(seen.size()), 32'd1);
        if (seen.size() == 1) chk("coincide_addr", seen[0].addr, B1);
        chk("coincide_cnt", 32'(line_cnt_o), 32'd1);

        // Random traffic
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            rst_i       = ($urandom_range(0, 599) == 0);
            line_done_i = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 5))
                0:       h_count_i = 16'd0;
                1:       h_count_i = 16'($urandom_range(1, 16));
                2:       h_count_i = 16'($urandom_range(17, 300));
                3:       h_count_i = 16'($urandom_range(1, 2000));
                4:       h_count_i = 16'(16 * $urandom_range(1, 40));
                default: h_count_i = 16'($urandom_range(600, 1000));
            endcase
            if ($urandom_range(0, 39) == 0) frame_valid_i = !frame_valid_i;
        end
        @(negedge clk);
        rst_i = 1'b0;
        line_done_i = 1'b0;
        wait_idle("idle_final");
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
